diff_scan: RTL

DIFF_SCAN -- requirements
Module: diff_scan

---
 rtl/diff_scan_pkg.sv | 17 +
 rtl/diff_chunk.sv | 30 +++
 rtl/diff_scan.sv | 136 +++++++++++++
 3 files changed

// File: rtl/diff_scan_pkg.sv
// Shared encodings for the diff_scan block: operand-difference scan modes and FSM states.
package diff_scan_pkg;

    localparam logic [1:0] MODE_LOW  = 2'b00;
    localparam logic [1:0] MODE_HIGH = 2'b01;
    localparam logic [1:0] MODE_HAM  = 2'b10;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Mode 11 behaves exactly like the lowest-index scan.
    function automatic logic [1:0] norm_mode(input logic [1:0] m);
        return ((m == MODE_HIGH) || (m == MODE_HAM)) ? m : MODE_LOW;
    endfunction

endpackage

// File: rtl/diff_chunk.sv
// Combinational slice analyser: any-set flag, lowest/highest set-bit index and popcount.
module diff_chunk #(
    parameter  int unsigned CHUNK = 8,
    localparam int unsigned IW    = (CHUNK > 1) ? $clog2(CHUNK) : 1,
    localparam int unsigned PW    = $clog2(CHUNK + 1)
) (
    input  logic [CHUNK-1:0] slice,
    output logic             any,
    output logic [IW-1:0]    lo_idx,
    output logic [IW-1:0]    hi_idx,
    output logic [PW-1:0]    pop
);

    always_comb begin
        any    = |slice;
        lo_idx = '0;
        hi_idx = '0;
        pop    = '0;
        for (int unsigned i = 0; i < CHUNK; i++) begin
            if (slice[i]) begin
                hi_idx = IW'(i);
                pop    = pop + PW'(1);
            end
        end
        for (int unsigned i = CHUNK; i > 0; i--) begin
            if (slice[i-1]) lo_idx = IW'(i - 1);
        end
    end

endmodule

// File: rtl/diff_scan.sv
// Multi-cycle scan of a^b one CHUNK slice per cycle: lowest/highest differing bit or Hamming distance.
module diff_scan
    import diff_scan_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [WIDTH-1:0]         a,
    input  logic [WIDTH-1:0]         b,
    input  logic [1:0]               mode,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(WIDTH):0]   result,
    output logic                     equal
);

    localparam int unsigned NCH = WIDTH / CHUNK;
    localparam int unsigned RW  = $clog2(WIDTH) + 1;
    localparam int unsigned CW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned IW  = (CHUNK > 1) ? $clog2(CHUNK) : 1;
    localparam int unsigned PW  = $clog2(CHUNK + 1);

    logic [1:0]       state_q,  state_d;
    logic [WIDTH-1:0] diff_q,   diff_d;
    logic [1:0]       mode_q,   mode_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic [RW-1:0]    acc_q,    acc_d;
    logic [RW-1:0]    result_q, result_d;
    logic             equal_q,  equal_d;

    logic [CW-1:0]    idx;
    logic [CHUNK-1:0] slice;
    logic             any;
    logic [IW-1:0]    lo_idx, hi_idx;
    logic [PW-1:0]    pop;
    logic [RW-1:0]    base, pos, ham_sum;
    logic             last;

    diff_chunk #(.CHUNK(CHUNK)) u_chunk (
        .slice  (slice),
        .any    (any),
        .lo_idx (lo_idx),
        .hi_idx (hi_idx),
        .pop    (pop)
    );

    // Counter always counts up; high mode walks slices from the top by mirroring it.
    always_comb begin
        idx   = (mode_q == MODE_HIGH) ? (CW'(NCH - 1) - cnt_q) : cnt_q;
        slice = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (CW'(i) == idx) slice = diff_q[i*CHUNK +: CHUNK];
        end
        base    = RW'(idx) * RW'(CHUNK);
        pos     = base + RW'((mode_q == MODE_HIGH) ? hi_idx : lo_idx);
        ham_sum = acc_q + RW'(pop);
        last    = (cnt_q == CW'(NCH - 1));
    end

    always_comb begin
        state_d  = state_q;
        diff_d   = diff_q;
        mode_d   = mode_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        result_d = result_q;
        equal_d  = equal_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d  = ST_SCAN;
                    diff_d   = a ^ b;
                    mode_d   = norm_mode(mode);
                    cnt_d    = '0;
                    acc_d    = '0;
                    result_d = '0;
                    equal_d  = 1'b0;
                end else if (state_q == ST_DONE) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (mode_q == MODE_HAM) begin
                    acc_d = ham_sum;
                    if (last) begin
                        state_d  = ST_DONE;
                        result_d = ham_sum;
                        equal_d  = (ham_sum == '0);
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else if (any) begin
                    state_d  = ST_DONE;
                    result_d = pos;
                    equal_d  = 1'b0;
                end else if (last) begin
                    state_d  = ST_DONE;
                    result_d = '0;
                    equal_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            diff_q   <= '0;
            mode_q   <= MODE_LOW;
            cnt_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
            equal_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            diff_q   <= diff_d;
            mode_q   <= mode_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            equal_q  <= equal_d;
        end
    end

    assign busy   = (state_q == ST_SCAN);
    assign done   = (state_q == ST_DONE);
    assign result = result_q;
    assign equal  = equal_q;

endmodule
